// File: rtl/display_link_master_if.sv
// Command, response and line signals of the single-wire display register link.
//   master : the link initiator (display_link_master)
//   slave  : the host command side plus the line/target side
interface display_link_master_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              clock_target;
  logic              sdio_o;
  logic              sdio_oe;
  logic              sdio_i;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, sdio_i,
    output cmd_ready, rsp_valid, rsp_rdata, busy, clock_target, sdio_o, sdio_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, sdio_i,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, clock_target, sdio_o, sdio_oe
  );
endinterface

// File: rtl/display_link_master.sv
// Host-side initiator for the single-wire display register link.
// Serialises write/read commands onto sdio with a forwarded bit clock and
// captures the 32-bit read reply.
//   c125  : system clock
//   reset : async active-low reset
//   bus   : command/response handshake and sdio/clock_target line signals
module display_link_master #(
  parameter int unsigned DIV = 2,  // c125 cycles per half bit period (>=1)
  parameter int unsigned TA  = 2   // turnaround bit periods (>=1)
) (
  input  logic                  c125,
  input  logic                  reset,
  display_link_master_if.master bus
);

  localparam int unsigned     PH_W    = $clog2(DIV) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(DIV);
  localparam logic [5:0]      N_ADDR  = 6'd7;
  localparam logic [5:0]      N_DATA  = 6'd31;
  localparam logic [5:0]      N_TA    = 6'(TA - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RW, S_ADDR, S_WDATA, S_TA, S_RDATA, S_STOP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PH_W-1:0] r_phase, w_phase_nxt;
  logic [5:0]      r_bitcnt, w_bitcnt_nxt;
  logic            r_write, w_write_nxt;
  logic [7:0]      r_addr, w_addr_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic [31:0]     r_rxsh, w_rxsh_nxt;

  logic            r_cmd_ready, w_cmd_ready_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_clock_target, w_clock_target_nxt;
  logic            r_sdio_o, w_sdio_o_nxt;
  logic            r_sdio_oe, w_sdio_oe_nxt;

  logic            w_bit_end;
  logic            w_last;

  // State and registered outputs
  always_ff @(posedge c125 or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_phase        <= '0;
      r_bitcnt       <= '0;
      r_write        <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rxsh         <= '0;
      r_cmd_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_busy         <= 1'b0;
      r_clock_target <= 1'b0;
      r_sdio_o       <= 1'b1;
      r_sdio_oe      <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_phase        <= w_phase_nxt;
      r_bitcnt       <= w_bitcnt_nxt;
      r_write        <= w_write_nxt;
      r_addr         <= w_addr_nxt;
      r_wdata        <= w_wdata_nxt;
      r_rxsh         <= w_rxsh_nxt;
      r_cmd_ready    <= w_cmd_ready_nxt;
      r_rsp_valid    <= w_rsp_valid_nxt;
      r_rsp_rdata    <= w_rsp_rdata_nxt;
      r_busy         <= w_busy_nxt;
      r_clock_target <= w_clock_target_nxt;
      r_sdio_o       <= w_sdio_o_nxt;
      r_sdio_oe      <= w_sdio_oe_nxt;
    end
  end

  // Next state, counters, and next values of every registered output
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_bitcnt_nxt    = r_bitcnt;
    w_write_nxt     = r_write;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_rxsh_nxt      = r_rxsh;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;

    w_bit_end = (r_state != S_IDLE) && (r_phase == PH_LAST);
    w_last    = w_bit_end && (r_bitcnt == 6'd0);

    if (r_state != S_IDLE) begin
      w_phase_nxt = w_bit_end ? '0 : r_phase + 1'b1;
    end
    // Bit counter counts down the remaining bits of the current state
    if (w_bit_end && !w_last) begin
      w_bitcnt_nxt = r_bitcnt - 6'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_write_nxt  = bus.cmd_write;
          w_addr_nxt   = bus.cmd_addr;
          w_wdata_nxt  = bus.cmd_wdata;
          w_state_nxt  = S_START;
          w_phase_nxt  = '0;
          w_bitcnt_nxt = 6'd0;
        end
      end
      S_START: if (w_last) begin
        w_state_nxt  = S_RW;
        w_bitcnt_nxt = 6'd0;
      end
      S_RW: if (w_last) begin
        w_state_nxt  = S_ADDR;
        w_bitcnt_nxt = N_ADDR;
      end
      S_ADDR: if (w_last) begin
        w_state_nxt  = r_write ? S_WDATA : S_TA;
        w_bitcnt_nxt = r_write ? N_DATA : N_TA;
      end
      S_WDATA: if (w_last) begin
        w_state_nxt  = S_STOP;
        w_bitcnt_nxt = 6'd0;
      end
      S_TA: if (w_last) begin
        w_state_nxt  = S_RDATA;
        w_bitcnt_nxt = N_DATA;
      end
      S_RDATA: begin
        // Sample on the last high-phase cycle, MSB first
        if (w_bit_end) w_rxsh_nxt = {r_rxsh[30:0], bus.sdio_i};
        if (w_last) begin
          w_state_nxt  = S_STOP;
          w_bitcnt_nxt = 6'd0;
        end
      end
      S_STOP: if (w_last) begin
        w_state_nxt     = S_IDLE;
        w_rsp_valid_nxt = 1'b1;
        if (!r_write) w_rsp_rdata_nxt = r_rxsh;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs follow the upcoming state so they stay registered without lag
    w_busy_nxt         = (w_state_nxt != S_IDLE);
    w_cmd_ready_nxt    = (w_state_nxt == S_IDLE);
    w_clock_target_nxt = (w_state_nxt != S_IDLE) && (w_phase_nxt >= PH_HIGH);
    w_sdio_oe_nxt      = !((w_state_nxt == S_TA) || (w_state_nxt == S_RDATA));
    case (w_state_nxt)
      S_START: w_sdio_o_nxt = 1'b0;
      S_RW:    w_sdio_o_nxt = w_write_nxt;
      S_ADDR:  w_sdio_o_nxt = w_addr_nxt[w_bitcnt_nxt[2:0]];
      S_WDATA: w_sdio_o_nxt = w_wdata_nxt[w_bitcnt_nxt[4:0]];
      default: w_sdio_o_nxt = 1'b1;
    endcase
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.busy         = r_busy;
  assign bus.clock_target = r_clock_target;
  assign bus.sdio_o       = r_sdio_o;
  assign bus.sdio_oe      = r_sdio_oe;

endmodule
